move_cmd_queue: RTL and testbench

- Sits directly downstream of the four per-direction button debouncers in the 2048 design.
- Each debouncer emits a short train of up to 3 one-cycle pulses per physical press; this block collapses each train into exactly one move command.
- Arbitrates simultaneous directions and buffers commands in a small FIFO.
- Presents commands to the board-update logic over a valid/ready handshake.

---
 rtl/move_pkg.sv | 11 +
 rtl/edge_holdoff.sv | 42 ++++
 rtl/move_cmd_queue.sv | 112 +++++++++++
 tb/tb_move_cmd_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// Direction encoding shared by the move command queue and the board-update logic.
package move_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

endpackage

// File: rtl/edge_holdoff.sv
// Rising-edge detector with a holdoff window, so that one debouncer pulse train
// yields exactly one armed-rise strobe.
module edge_holdoff #(
    parameter int HOLDOFF = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic armed_o
);

    localparam int HW = $clog2(HOLDOFF);

    logic          prev_q;
    logic [HW-1:0] cnt_q;
    logic [HW-1:0] cnt_d;
    logic          rise;

    assign rise    = btn_i & ~prev_q;
    assign armed_o = rise && (cnt_q == '0);

    // An armed rise reopens the window; otherwise the window drains to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (armed_o) begin
            cnt_d = HW'(HOLDOFF - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= btn_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/move_cmd_queue.sv
// Collapses debounced direction pulse trains into single move commands, arbitrates
// them and queues them in a first-word fall-through FIFO. Optional macro: MOVE_DEDUP_EN.
module move_cmd_queue
    import move_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    output logic                       cmd_valid,
    output logic [1:0]                 cmd_dir,
    input  logic                       cmd_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [3:0]    armed;
    logic [3:0]    btnVec;
    dir_t          pushDir;
    logic          pushReq;
    logic          dup;
    logic          accept;
    logic          drop;
    logic          pop;

    dir_t          mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    assign btnVec = {btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < 4; g++) begin : g_edge
        edge_holdoff #(.HOLDOFF(HOLDOFF)) u_edge (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btnVec[g]),
            .armed_o (armed[g])
        );
    end

    // Losing directions are simply dropped; their holdoff windows still started.
    always_comb begin
        pushReq = |armed;
        pushDir = DIR_UP;
        if (armed[0])      pushDir = DIR_UP;
        else if (armed[1]) pushDir = DIR_DOWN;
        else if (armed[2]) pushDir = DIR_LEFT;
        else if (armed[3]) pushDir = DIR_RIGHT;
    end

    assign pop = (count_q != '0) && cmd_ready;

`ifdef MOVE_DEDUP_EN
    dir_t tailDir;
    assign tailDir = mem_q[wrPtr_q - PW'(1)];
    assign dup     = (count_q != '0) && (tailDir == pushDir);
`else
    assign dup     = 1'b0;
`endif

    assign accept = pushReq && !dup && ((count_q != DEPTH_C) || pop);
    assign drop   = pushReq && !dup && !accept;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (accept) wrPtr_d = wrPtr_q + PW'(1);
        if (pop)    rdPtr_d = rdPtr_q + PW'(1);
        if (accept && !pop)      count_d = count_q + CW'(1);
        else if (pop && !accept) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_q[wrPtr_q] <= pushDir;
        end
    end

    assign cmd_valid  = (count_q != '0);
    assign cmd_dir    = cmd_valid ? mem_q[rdPtr_q] : DIR_UP;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed self-checking bench for move_cmd_queue (DEPTH=4, HOLDOFF=8).
module tb_move_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btnVec;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    move_cmd_queue #(.DEPTH(4), .HOLDOFF(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btnVec[0]),
        .btn_down   (btnVec[1]),
        .btn_left   (btnVec[2]),
        .btn_right  (btnVec[3]),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of button levels; the DUT samples them at the next posedge.
    task automatic applyStimulus(input logic [3:0] vec);
        btnVec = vec;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000);
    endtask

    task automatic popOne();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    // A clean press: one high cycle then low, followed by a quiet gap.
    task automatic press(input logic [3:0] vec, input int gap);
        applyStimulus(vec);
        idle(gap);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        btnVec    = 4'b0000;
        cmd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset valid", 32'(cmd_valid), 0);
        checkOutput("reset count", 32'(fifo_count), 0);
        checkOutput("reset overflow", 32'(overflow), 0);
        checkOutput("reset dir", 32'(cmd_dir), 0);
        idle(3);

        // Single up press with a 1,0,1,0 pulse train.
        applyStimulus(4'b0001);
        checkOutput("up valid", 32'(cmd_valid), 1);
        checkOutput("up dir", 32'(cmd_dir), 0);
        checkOutput("up count", 32'(fifo_count), 1);
        applyStimulus(4'b0000);
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);
        checkOutput("up train merged", 32'(fifo_count), 1);
        idle(10);
        popOne();
        checkOutput("empty valid", 32'(cmd_valid), 0);
        checkOutput("empty count", 32'(fifo_count), 0);
        checkOutput("empty dir", 32'(cmd_dir), 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checkOutput("ready on empty", 32'(fifo_count), 0);
        idle(5);

        // Holdoff boundary: a rise 7 cycles after acceptance is ignored, 9 cycles after is taken.
        applyStimulus(4'b0010);
        idle(6);
        applyStimulus(4'b0010);
        checkOutput("holdoff inside", 32'(fifo_count), 1);
        applyStimulus(4'b0000);
        applyStimulus(4'b0010);
        checkOutput("holdoff expired", 32'(fifo_count), 2);
        popOne();
        popOne();
        idle(10);

        // Left and right together: left wins, right's train is absorbed.
        applyStimulus(4'b1100);
        checkOutput("lr count", 32'(fifo_count), 1);
        checkOutput("lr dir", 32'(cmd_dir), 2);
        applyStimulus(4'b0000);
        applyStimulus(4'b1000);
        applyStimulus(4'b0000);
        applyStimulus(4'b1000);
        applyStimulus(4'b0000);
        checkOutput("right absorbed", 32'(fifo_count), 1);
        popOne();
        idle(10);

        // Overflow: five presses with the consumer stalled.
        press(4'b0001, 19);
        press(4'b0010, 19);
        press(4'b0100, 19);
        press(4'b1000, 19);
        checkOutput("full count", 32'(fifo_count), 4);
        checkOutput("full no overflow", 32'(overflow), 0);
        press(4'b0001, 19);
        checkOutput("overflow count", 32'(fifo_count), 4);
        checkOutput("overflow set", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain order", 32'(cmd_dir), i);
            popOne();
        end
        checkOutput("drained", 32'(fifo_count), 0);
        checkOutput("overflow sticky", 32'(overflow), 1);

        // Reset with three queued entries and a running holdoff.
        press(4'b0001, 19);
        press(4'b0010, 19);
        applyStimulus(4'b0100);
        applyStimulus(4'b0000);
        checkOutput("pre-reset count", 32'(fifo_count), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid reset valid", 32'(cmd_valid), 0);
        checkOutput("mid reset count", 32'(fifo_count), 0);
        checkOutput("mid reset overflow", 32'(overflow), 0);
        applyStimulus(4'b0000);
        applyStimulus(4'b0100);
        checkOutput("post reset press", 32'(fifo_count), 1);
        checkOutput("post reset dir", 32'(cmd_dir), 2);
        popOne();
        idle(10);

        // Full FIFO with a pop and a push in the same cycle.
        press(4'b0001, 19);
        press(4'b0010, 19);
        press(4'b0100, 19);
        press(4'b1000, 19);
        cmd_ready = 1'b1;
        applyStimulus(4'b0010);
        cmd_ready = 1'b0;
        checkOutput("push+pop count", 32'(fifo_count), 4);
        checkOutput("push+pop overflow", 32'(overflow), 0);
        checkOutput("push+pop head", 32'(cmd_dir), 1);
        applyStimulus(4'b0000);
        checkOutput("stall stable dir", 32'(cmd_dir), 1);
        popOne();
        checkOutput("order 2", 32'(cmd_dir), 2);
        popOne();
        checkOutput("order 3", 32'(cmd_dir), 3);
        popOne();
        checkOutput("order tail", 32'(cmd_dir), 1);
        popOne();
        checkOutput("drained again", 32'(fifo_count), 0);
        idle(10);

        // Repeated same-direction presses while stalled.
        press(4'b0010, 19);
        press(4'b0010, 19);
`ifdef MOVE_DEDUP_EN
        checkOutput("repeat down count", 32'(fifo_count), 1);
`else
        checkOutput("repeat down count", 32'(fifo_count), 2);
`endif
        checkOutput("repeat down overflow", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
